// File: rtl/div_ctrl.sv
// div_ctrl: issues DIV/DIVU operations to a multi-cycle divider, stalls the
// pipeline while the divide is pending and writes the result into HI/LO.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_rs_i,
    input  logic [31:0] ex_rt_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        cool_cnt_q, cool_cnt_d;
    logic [31:0] op1_q, op2_q;
    logic        sgn_q;
    logic [31:0] hi_q, lo_q;
    logic        issue;
    logic        capture;

    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign div_signed_o = sgn_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

    // Next-state and control outputs; COOL lets the divider fully drain.
    always_comb begin
        state_d     = state_q;
        cool_cnt_d  = cool_cnt_q;
        issue       = 1'b0;
        capture     = 1'b0;
        stall_o     = 1'b0;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        hilo_we_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_div_i && !flush_i) begin
                    issue   = 1'b1;
                    stall_o = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_d     = COOL;
                    cool_cnt_d  = 1'b0;
                end else begin
                    div_start_o = 1'b1;
                    if (div_ready_i) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush_i) begin
                    state_d    = COOL;
                    cool_cnt_d = 1'b0;
                end else if (!stall_i) begin
                    hilo_we_o  = 1'b1;
                    state_d    = COOL;
                    cool_cnt_d = 1'b0;
                end
            end
            COOL: begin
                stall_o = ex_div_i;
                if (cool_cnt_q) begin
                    state_d    = IDLE;
                    cool_cnt_d = 1'b0;
                end else begin
                    cool_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                cool_cnt_d = 1'b0;
            end
        endcase
        if (rst) begin
            issue       = 1'b0;
            capture     = 1'b0;
            stall_o     = 1'b0;
            div_start_o = 1'b0;
            div_annul_o = 1'b0;
            hilo_we_o   = 1'b0;
        end
    end

    // State, operand latch at issue and result capture on divider ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cool_cnt_q <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            sgn_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cool_cnt_q <= cool_cnt_d;
            if (issue) begin
                op1_q <= ex_rs_i;
                op2_q <= ex_rt_i;
                sgn_q <= ex_signed_i;
            end
            if (capture) begin
                hi_q <= div_result_i[63:32];
                lo_q <= div_result_i[31:0];
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl with a scripted divider response.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_div_i;
    logic        ex_signed_i;
    logic [31:0] ex_rs_i;
    logic [31:0] ex_rt_i;
    logic        stall_i;
    logic        flush_i;
    logic        stall_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total;
    int bad;

    typedef struct {
        logic        sgn;
        logic [31:0] rs;
        logic [31:0] rt;
        int          lat;
        logic [63:0] res;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_i     (ex_div_i),
        .ex_signed_i  (ex_signed_i),
        .ex_rs_i      (ex_rs_i),
        .ex_rt_i      (ex_rt_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input logic st, input logic sg,
                           input logic an, input logic we);
        chk({nm, ".stall"}, stall_o, st);
        chk({nm, ".start"}, div_start_o, sg);
        chk({nm, ".annul"}, div_annul_o, an);
        chk({nm, ".hilo_we"}, hilo_we_o, we);
    endtask

    // IDLE cycle presenting a new divide in EX.
    task automatic issue(input vec_t v, input string nm);
        @(negedge clk);
        ex_div_i     = 1'b1;
        ex_signed_i  = v.sgn;
        ex_rs_i      = v.rs;
        ex_rt_i      = v.rt;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        div_ready_i  = 1'b0;
        #1;
        chk_ctl({nm, ".issue"}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // BUSY cycles until ready, optional DONE stalls, then the write/flush cycle.
    task automatic complete(input vec_t v, input int nstall,
                            input bit fl_done, input string nm);
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            ex_div_i     = 1'b0;
            ex_rs_i      = 32'h0;
            ex_rt_i      = 32'hDEAD;
            ex_signed_i  = ~v.sgn;
            div_ready_i  = (k == v.lat);
            div_result_i = (k == v.lat) ? v.res : 64'hFFFF_0000_FFFF_0000;
            #1;
            chk_ctl({nm, ".busy"}, 1'b1, 1'b1, 1'b0, 1'b0);
            chk({nm, ".op1"}, div_op1_o, v.rs);
            chk({nm, ".op2"}, div_op2_o, v.rt);
            chk({nm, ".sgn"}, div_signed_o, v.sgn);
        end
        for (int s = 0; s < nstall; s++) begin
            @(negedge clk);
            stall_i      = 1'b1;
            div_ready_i  = 1'b1;
            div_result_i = 64'h1234_5678_9ABC_DEF0;
            #1;
            chk_ctl({nm, ".done_stall"}, 1'b0, 1'b0, 1'b0, 1'b0);
            chk({nm, ".hold_hi"}, hi_o, v.ehi);
            chk({nm, ".hold_lo"}, lo_o, v.elo);
        end
        @(negedge clk);
        stall_i     = 1'b0;
        flush_i     = fl_done;
        div_ready_i = 1'b0;
        #1;
        chk_ctl({nm, ".done"}, 1'b0, 1'b0, 1'b0, !fl_done);
        chk({nm, ".hi"}, hi_o, v.ehi);
        chk({nm, ".lo"}, lo_o, v.elo);
    endtask

    // Two COOL cycles with no pending DIV; a stray ready must be ignored.
    task automatic cool_idle(input logic [31:0] ehi, input logic [31:0] elo,
                             input string nm);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ex_div_i     = 1'b0;
            stall_i      = 1'b0;
            flush_i      = 1'b0;
            div_ready_i  = 1'b1;
            div_result_i = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            chk_ctl({nm, ".cool"}, 1'b0, 1'b0, 1'b0, 1'b0);
            chk({nm, ".cool_hi"}, hi_o, ehi);
            chk({nm, ".cool_lo"}, lo_o, elo);
        end
        div_ready_i = 1'b0;
    endtask

    vec_t tbl[5];
    vec_t va;
    vec_t vb;

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        ex_div_i     = 1'b0;
        ex_signed_i  = 1'b0;
        ex_rs_i      = '0;
        ex_rt_i      = '0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        div_result_i = '0;
        div_ready_i  = 1'b0;

        tbl[0] = '{1'b0, 32'd100, 32'd7, 3, 64'h00000002_0000000E,
                   32'd2, 32'd14};
        tbl[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 4, 64'hFFFFFFFF_FFFFFFFD,
                   32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'd16, 5, 64'h0000000F_0FFFFFFF,
                   32'h0000000F, 32'h0FFFFFFF};
        tbl[3] = '{1'b0, 32'd8, 32'd2, 2, 64'h00000000_00000004,
                   32'd0, 32'd4};
        tbl[4] = '{1'b1, 32'd1, 32'd1, 1, 64'h00000000_00000001,
                   32'd0, 32'd1};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.hi", hi_o, 32'd0);
        chk("reset.lo", lo_o, 32'd0);
        chk("reset.op1", div_op1_o, 32'd0);

        // Flush in IDLE blocks issue
        @(negedge clk);
        ex_div_i = 1'b1;
        flush_i  = 1'b1;
        #1;
        chk_ctl("idle_flush", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        ex_div_i = 1'b0;
        flush_i  = 1'b0;
        #1;
        chk_ctl("idle_after_flush", 1'b0, 1'b0, 1'b0, 1'b0);

        // Table-driven plain divides
        for (int i = 0; i < 5; i++) begin
            issue(tbl[i], $sformatf("v%0d", i));
            complete(tbl[i], 0, 1'b0, $sformatf("v%0d", i));
            cool_idle(tbl[i].ehi, tbl[i].elo, $sformatf("v%0d", i));
        end

        // Divide by zero then a DIV waiting through COOL
        va = '{1'b1, 32'd5, 32'd0, 6, 64'h0, 32'd0, 32'd0};
        vb = '{1'b1, 32'd9, 32'd3, 3, 64'h00000000_00000003, 32'd0, 32'd3};
        issue(va, "dz");
        complete(va, 0, 1'b0, "dz");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            flush_i     = 1'b0;
            ex_div_i    = 1'b1;
            ex_signed_i = vb.sgn;
            ex_rs_i     = vb.rs;
            ex_rt_i     = vb.rt;
            #1;
            chk_ctl("b2b.cool", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        issue(vb, "b2b");
        complete(vb, 0, 1'b0, "b2b");
        cool_idle(vb.ehi, vb.elo, "b2b");

        // Flush on the 10th BUSY cycle
        va = '{1'b0, 32'd77, 32'd5, 20, 64'h0, 32'd0, 32'd0};
        issue(va, "fb");
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            ex_div_i = 1'b0;
            #1;
            chk_ctl("fb.busy", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        flush_i      = 1'b1;
        div_ready_i  = 1'b1;
        div_result_i = 64'h0000_0002_0000_000F;
        #1;
        chk("fb.annul", div_annul_o, 1'b1);
        chk("fb.start", div_start_o, 1'b0);
        chk("fb.hilo_we", hilo_we_o, 1'b0);
        cool_idle(vb.ehi, vb.elo, "fb");
        issue(tbl[3], "fb_next");
        complete(tbl[3], 0, 1'b0, "fb_next");
        cool_idle(32'd0, 32'd4, "fb_next");

        // Five stalled DONE cycles, then one write
        va = '{1'b0, 32'd50, 32'd6, 2, 64'h00000002_00000008, 32'd2, 32'd8};
        issue(va, "sd");
        complete(va, 5, 1'b0, "sd");
        cool_idle(32'd2, 32'd8, "sd");

        // Flush while stalled in DONE: no write
        va = '{1'b0, 32'd21, 32'd4, 2, 64'h00000001_00000005, 32'd1, 32'd5};
        issue(va, "fd");
        complete(va, 2, 1'b1, "fd");
        cool_idle(32'd1, 32'd5, "fd");

        // Reset in the middle of BUSY
        va = '{1'b0, 32'd100, 32'd7, 20, 64'h0, 32'd0, 32'd0};
        issue(va, "rb");
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            ex_div_i = 1'b0;
            #1;
            chk_ctl("rb.busy", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst     = 1'b1;
        flush_i = 1'b1;
        #1;
        chk_ctl("rb.in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst     = 1'b0;
        flush_i = 1'b0;
        #1;
        chk_ctl("rb.after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rb.hi", hi_o, 32'd0);
        chk("rb.lo", lo_o, 32'd0);
        chk("rb.op1", div_op1_o, 32'd0);
        chk("rb.op2", div_op2_o, 32'd0);
        chk("rb.sgn", div_signed_o, 1'b0);
        va = '{1'b0, 32'd1, 32'd1, 3, 64'h00000000_00000001, 32'd0, 32'd1};
        issue(va, "rb_next");
        complete(va, 0, 1'b0, "rb_next");
        cool_idle(32'd0, 32'd1, "rb_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 ex_div_i  in  1  EX stage holds a DIV/DIVU instruction.
REQ-004 ex_signed_i  in  1  1=DIV, 0=DIVU; sampled with ex_div_i.
REQ-005 ex_rs_i / ex_rt_i  in  32 each  dividend / divisor from EX.
REQ-006 stall_i  in  1  pipeline held by another source; EX instruction does not advance.
REQ-007 flush_i  in  1  exception/flush kills EX instruction.
REQ-008 stall_o  out  1  request pipeline stall while division is pending.
REQ-009 div_start_o, div_annul_o, div_signed_o  out  1 each  divider control.
REQ-010 div_op1_o / div_op2_o  out  32 each  divider operands.
REQ-011 div_result_i  in  64  {remainder, quotient} from divider; div_ready_i  in  1  result valid.
REQ-012 hilo_we_o  out  1; hi_o / lo_o  out  32 each  HI/LO write port.

Function
REQ-013 States: IDLE, BUSY, DONE, COOL; encoded in 2 bits.
REQ-014 IDLE: ex_div_i=1 and flush_i=0 -> latch ex_rs_i, ex_rt_i, ex_signed_i into operand registers; assert div_start_o next cycle; go BUSY; stall_o=1 combinationally in this cycle.
REQ-015 Operand and signed registers drive div_op1_o/div_op2_o/div_signed_o and stay constant from issue until the controller leaves BUSY; EX input changes are ignored.
REQ-016 BUSY: div_start_o=1, stall_o=1; div_ready_i=1 -> capture div_result_i[63:32] into hi_o, [31:0] into lo_o; deassert div_start_o next cycle; go DONE.
REQ-017 DONE: div_start_o=0, stall_o=0; stall_i=0 -> hilo_we_o=1 for exactly that cycle, go COOL; stall_i=1 -> stay DONE, hilo_we_o=0, hi_o/lo_o held.
REQ-018 COOL: 2-cycle counter; div_start_o=0; stall_o=ex_div_i; then IDLE. Guarantees the divider has returned to its free state (worst case: divide-by-zero path) before the next start.
REQ-019 flush_i=1 in BUSY: div_annul_o=1 for one cycle, div_start_o=0, no HI/LO write, go COOL.
REQ-020 flush_i=1 in DONE: no HI/LO write (flush overrides stall_i), go COOL.
REQ-021 flush_i=1 in IDLE: no issue, stay IDLE; in COOL: ignored.
REQ-022 div_annul_o=0 in all other cases; hilo_we_o never asserted outside DONE.
REQ-023 Divisor zero is not special-cased: the divider result is passed through unchanged, and the controller sequences it like any other divide.
REQ-024 Back-to-back divides: the second DIV waits in COOL with stall_o=1, then issues from IDLE; minimum 2 idle cycles between div_start_o pulses.
REQ-025 div_ready_i in IDLE, DONE or COOL is ignored.

Reset
REQ-026 rst=1 -> state IDLE, COOL counter 0, operand/signed registers 0, hi_o=lo_o=0.
REQ-027 rst=1 -> stall_o=0, div_start_o=0, div_annul_o=0, hilo_we_o=0 in the following cycle.
REQ-028 rst takes priority over flush_i and all other inputs, including mid-division. The divider shares the same rst.

Verification
REQ-029 DIVU 100/7, no stalls -> stall_o high until DONE; single hilo_we_o pulse with hi_o=2, lo_o=14; div_start_o high only in BUSY.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD; ex_rs_i changed to 0 during BUSY has no effect.
REQ-031 DIV 5/0 -> completes without hang; hilo_we_o writes the divider's zero-divisor result (0/0). The next DIV 9/3 issued immediately -> waits 2 COOL cycles, then hi_o=0, lo_o=3.
REQ-032 flush_i at 10th BUSY cycle -> div_annul_o pulse, no hilo_we_o, COOL then IDLE. A following DIVU 8/2 -> lo_o=4.
REQ-033 stall_i=1 for 5 cycles while DONE -> hilo_we_o=0 and hi_o/lo_o stable throughout. On stall_i falling -> exactly one hilo_we_o pulse. flush_i in DONE -> no pulse.
REQ-034 rst asserted mid-BUSY -> all outputs at reset values next cycle; a new DIVU 1/1 then yields hi_o=0, lo_o=1.
